// File: rtl/sdram_frame_arbiter.sv
// Round-robin single-burst scheduler between the camera write stream and the VGA read stream.
// Optional double-buffered banking is enabled by defining SDRAM_PINGPONG_EN.
module sdram_frame_arbiter #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [1:0]  BANK        = 2'b01
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_vsync,
  input  logic              rd_vsync,
  output logic              write_en,
  input  logic              write_ack,
  output logic              read_en,
  input  logic              read_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bank,
  output logic              frame_ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic                wr_pend_q, wr_pend_d;
  logic                rd_pend_q, rd_pend_d;
  logic                last_wr_q, last_wr_d;
  logic                frame_ready_q, frame_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          bank_q, bank_d;

  logic                eligible_rd;
  logic                wr_wrap;
  logic                rd_wrap;
  logic                wr_frame_done;
  logic [1:0]          wr_bank_cur;
  logic [1:0]          rd_bank_cur;

`ifdef SDRAM_PINGPONG_EN
  // done_bank_q remembers which buffer holds the most recently completed frame.
  logic [1:0] wr_bank_q, wr_bank_d;
  logic [1:0] rd_bank_q, rd_bank_d;
  logic [1:0] done_bank_q, done_bank_d;

  assign wr_bank_cur = wr_bank_q;
  assign rd_bank_cur = rd_bank_q;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    done_bank_d = done_bank_q;
    if (rd_vsync) begin
      rd_bank_d = done_bank_q;
    end
    if (wr_frame_done) begin
      done_bank_d = wr_bank_q;
      wr_bank_d   = wr_bank_q ^ 2'b01;
    end
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      wr_bank_q   <= BANK;
      rd_bank_q   <= BANK;
      done_bank_q <= BANK;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      done_bank_q <= done_bank_d;
    end
  end
`else
  assign wr_bank_cur = BANK;
  assign rd_bank_cur = BANK;
`endif

  assign eligible_rd   = rd_req & frame_ready_q;
  assign wr_wrap       = (wr_cnt_q == LAST_ADDR);
  assign rd_wrap       = (rd_cnt_q == LAST_ADDR);
  assign wr_frame_done = (state_q == ST_WRITE) & write_ack & wr_wrap;

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    wr_pend_d     = wr_pend_q;
    rd_pend_d     = rd_pend_q;
    last_wr_d     = last_wr_q;
    frame_ready_d = frame_ready_q;
    addr_d        = addr_q;
    bank_d        = bank_q;

    // A stream that is not mid-burst restarts its frame immediately on vsync.
    if (wr_vsync && (state_q != ST_WRITE)) begin
      wr_cnt_d = '0;
    end
    if (rd_vsync && (state_q != ST_READ)) begin
      rd_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_req && !(eligible_rd && last_wr_q)) begin
          state_d = ST_WRITE;
          addr_d  = wr_vsync ? '0 : wr_cnt_q;
          bank_d  = wr_bank_cur;
        end else if (eligible_rd) begin
          state_d = ST_READ;
          addr_d  = rd_vsync ? '0 : rd_cnt_q;
          bank_d  = rd_bank_cur;
        end
      end
      ST_WRITE: begin
        if (write_ack) begin
          state_d   = ST_GAP;
          last_wr_d = 1'b1;
          wr_pend_d = 1'b0;
          wr_cnt_d  = (wr_pend_q || wr_vsync || wr_wrap) ? '0 : (wr_cnt_q + BURST_STEP);
          if (wr_wrap) begin
            frame_ready_d = 1'b1;
          end
        end else if (wr_vsync) begin
          wr_pend_d = 1'b1;
        end
      end
      ST_READ: begin
        if (read_ack) begin
          state_d   = ST_GAP;
          last_wr_d = 1'b0;
          rd_pend_d = 1'b0;
          rd_cnt_d  = (rd_pend_q || rd_vsync || rd_wrap) ? '0 : (rd_cnt_q + BURST_STEP);
        end else if (rd_vsync) begin
          rd_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      last_wr_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      addr_q        <= '0;
      bank_q        <= BANK;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      last_wr_q     <= last_wr_d;
      frame_ready_q <= frame_ready_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
    end
  end

  assign write_en    = (state_q == ST_WRITE);
  assign read_en     = (state_q == ST_READ);
  assign addr        = addr_q;
  assign bank        = bank_q;
  assign frame_ready = frame_ready_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Randomized self-checking bench for sdram_frame_arbiter against a burst-level reference model.
// Define SDRAM_PINGPONG_EN for both DUT and bench to exercise double buffering.
module tb_sdram_frame_arbiter;

  localparam int          AW   = 20;
  localparam int          BL   = 8;
  localparam int          FW   = 32;
  localparam logic [1:0]  BANK = 2'b01;

  localparam logic [1:0] B_NONE = 2'd0;
  localparam logic [1:0] B_W    = 2'd1;
  localparam logic [1:0] B_R    = 2'd2;

  logic          S_CLK;
  logic          RST_N;
  logic          wr_req, rd_req, wr_vsync, rd_vsync, write_ack, read_ack;
  logic          write_en, read_en, frame_ready, busy;
  logic [AW-1:0] addr;
  logic [1:0]    bank;

  sdram_frame_arbiter #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .BANK(BANK)
  ) dut (
    .S_CLK(S_CLK), .RST_N(RST_N),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_vsync(wr_vsync), .rd_vsync(rd_vsync),
    .write_en(write_en), .write_ack(write_ack),
    .read_en(read_en), .read_ack(read_ack),
    .addr(addr), .bank(bank),
    .frame_ready(frame_ready), .busy(busy)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit ack_rand = 1'b0;
  int wcnt = 0, rcnt = 0, wdly = 4, rdly = 4;

  // Burst-level view: which stream owns the bus, whether we sit in the post-burst gap,
  // each stream's frame pointer and the outputs the arbiter must present.
  typedef struct packed {
    logic [1:0]    burst;
    logic          gap;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wpend;
    logic          rpend;
    logic          last_w;
    logic          ready;
    logic [AW-1:0] addr;
    logic [1:0]    bank;
    logic [1:0]    wbank;
    logic [1:0]    rbank;
    logic [1:0]    dbank;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r        = '0;
    r.last_w = 1'b1;
    r.bank   = BANK;
    r.wbank  = BANK;
    r.rbank  = BANK;
    r.dbank  = BANK;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic rst_n, logic wreq, logic rreq,
                                        logic wv, logic rv, logic wack, logic rack);
    model_t     n;
    int         nxt;
    logic       rd_ok;
    logic [1:0] pick;
    if (!rst_n) return model_reset();
    n = c;
    if (rv) n.rbank = c.dbank;
    if (wv && c.burst != B_W) n.wptr = '0;
    if (rv && c.burst != B_R) n.rptr = '0;
    if (c.burst == B_W) begin
      if (wack) begin
        nxt = (int'(c.wptr) + BL) % FW;
        if (nxt == 0) begin
          n.ready = 1'b1;
`ifdef SDRAM_PINGPONG_EN
          n.dbank = c.wbank;
          n.wbank = c.wbank ^ 2'b01;
`endif
        end
        n.wptr   = (c.wpend || wv) ? '0 : AW'(nxt);
        n.wpend  = 1'b0;
        n.burst  = B_NONE;
        n.gap    = 1'b1;
        n.last_w = 1'b1;
      end else if (wv) begin
        n.wpend = 1'b1;
      end
    end else if (c.burst == B_R) begin
      if (rack) begin
        nxt      = (int'(c.rptr) + BL) % FW;
        n.rptr   = (c.rpend || rv) ? '0 : AW'(nxt);
        n.rpend  = 1'b0;
        n.burst  = B_NONE;
        n.gap    = 1'b1;
        n.last_w = 1'b0;
      end else if (rv) begin
        n.rpend = 1'b1;
      end
    end else if (c.gap) begin
      n.gap = 1'b0;
    end else begin
      rd_ok = rreq && c.ready;
      if (wreq && rd_ok) pick = c.last_w ? B_R : B_W;
      else if (wreq)     pick = B_W;
      else if (rd_ok)    pick = B_R;
      else               pick = B_NONE;
      if (pick == B_W) begin
        n.burst = B_W;
        n.addr  = n.wptr;
        n.bank  = c.wbank;
      end else if (pick == B_R) begin
        n.burst = B_R;
        n.addr  = n.rptr;
        n.bank  = c.rbank;
      end
    end
    return n;
  endfunction

  always @(posedge S_CLK)
    m <= model_next(m, RST_N, wr_req, rd_req, wr_vsync, rd_vsync, write_ack, read_ack);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: got no event, expected one within the cycle bound at %0t", name, $time);
  endtask

  always @(negedge S_CLK) begin
    if (chk_en) begin
      check("cyc_write_en",    32'(write_en),    32'(m.burst == B_W));
      check("cyc_read_en",     32'(read_en),     32'(m.burst == B_R));
      check("cyc_addr",        32'(addr),        32'(m.addr));
      check("cyc_bank",        32'(bank),        32'(m.bank));
      check("cyc_frame_ready", 32'(frame_ready), 32'(m.ready));
      check("cyc_busy",        32'(busy),        32'((m.burst != B_NONE) || m.gap));
    end
  end

  // Advance to the next negedge, acting as the SDRAM core that acks each burst.
  task automatic tick();
    @(negedge S_CLK);
    write_ack = 1'b0;
    read_ack  = 1'b0;
    wr_vsync  = 1'b0;
    rd_vsync  = 1'b0;
    if (write_en === 1'b1) begin
      wcnt++;
      if (wcnt == 1) wdly = ack_rand ? int'($urandom_range(1, 6)) : 4;
      if (wcnt == wdly) write_ack = 1'b1;
    end else begin
      wcnt = 0;
    end
    if (read_en === 1'b1) begin
      rcnt++;
      if (rcnt == 1) rdly = ack_rand ? int'($urandom_range(1, 6)) : 4;
      if (rcnt == rdly) read_ack = 1'b1;
    end else begin
      rcnt = 0;
    end
  endtask

  task automatic wait_en(input bit wr, output logic [AW-1:0] a, output logic [1:0] b);
    a = '0;
    b = '0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if ((wr && write_en === 1'b1) || (!wr && read_en === 1'b1)) begin
        a = addr;
        b = bank;
        return;
      end
    end
    fail_timeout(wr ? "wait_write_en" : "wait_read_en");
  endtask

  task automatic wait_end(input bit wr);
    for (int c = 0; c < 100; c++) begin
      tick();
      if ((wr && write_en === 1'b0) || (!wr && read_en === 1'b0)) return;
    end
    fail_timeout(wr ? "wait_write_end" : "wait_read_end");
  endtask

  task automatic wait_quiet();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (write_en === 1'b0 && read_en === 1'b0) return;
    end
    fail_timeout("wait_quiet");
  endtask

  task automatic do_burst(input bit wr, output logic [AW-1:0] a, output logic [1:0] b);
    if (wr) wr_req = 1'b1;
    else    rd_req = 1'b1;
    wait_en(wr, a, b);
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_end(wr);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    b;
    bit            prev_w;
    int            idle, grants, len;
    bit            found;

    RST_N = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_vsync = 1'b0; rd_vsync = 1'b0; write_ack = 1'b0; read_ack = 1'b0;
    repeat (3) tick();
    RST_N  = 1'b1;
    chk_en = 1'b1;

    check("rst_write_en", 32'(write_en), 0);
    check("rst_read_en",  32'(read_en), 0);
    check("rst_addr",     32'(addr), 0);
    check("rst_bank",     32'(bank), 32'(BANK));
    check("rst_busy",     32'(busy), 0);
    check("rst_ready",    32'(frame_ready), 0);

    // Reads stay gated until a full frame exists.
    rd_req = 1'b1;
    repeat (6) begin
      tick();
      check("read_gated", 32'(read_en), 0);
    end
    rd_req = 1'b0;

    wr_req = 1'b1;
    tick();
    check("grant_latency_wen", 32'(write_en), 1);
    check("grant_latency_addr", 32'(addr), 0);
    wait_end(1);
    for (int k = 1; k < 4; k++) begin
      wait_en(1, a, b);
      check("write_addr_seq", 32'(a), 32'(k * BL));
      check("ready_not_early", 32'(frame_ready), 0);
      wait_end(1);
    end
    check("ready_after_wrap", 32'(frame_ready), 1);
    wait_en(1, a, b);
    check("addr_after_wrap", 32'(a), 0);

    // Both streams requesting: grants alternate with two idle cycles between bursts.
    rd_req = 1'b1;
    prev_w = 1'b1;
    idle   = 0;
    grants = 0;
    for (int c = 0; c < 300 && grants < 4; c++) begin
      tick();
      if (write_en === 1'b1 || read_en === 1'b1) begin
        if (idle > 0) begin
          check("round_robin", 32'(read_en), 32'(prev_w));
          check("burst_spacing", 32'(idle), 2);
          prev_w = write_en;
          grants++;
        end
        idle = 0;
      end else begin
        idle++;
      end
    end
    if (grants < 4) fail_timeout("alternation");

    // Camera vsync in the middle of the burst at 16: burst finishes, next starts at 0.
    rd_req = 1'b0;
    wr_req = 1'b1;
    wait_quiet();
    found = 1'b0;
    for (int it = 0; it < 10; it++) begin
      wait_en(1, a, b);
      if (a == AW'(16)) begin
        found = 1'b1;
        break;
      end
      wait_end(1);
    end
    if (!found) fail_timeout("find_addr_16");
    wr_vsync = 1'b1;
    len = 1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (write_en === 1'b1) len++;
      else break;
    end
    check("vsync_burst_completes", 32'(len), 4);
    wait_en(1, a, b);
    check("vsync_restart_addr", 32'(a), 0);

    // Reset in the middle of a read burst, then a stray ack.
    wr_req = 1'b0;
    rd_req = 1'b1;
    wait_en(0, a, b);
    RST_N  = 1'b0;
    rd_req = 1'b0;
    tick();
    check("midburst_rst_ren", 32'(read_en), 0);
    check("midburst_rst_addr", 32'(addr), 0);
    check("midburst_rst_ready", 32'(frame_ready), 0);
    RST_N    = 1'b1;
    read_ack = 1'b1;
    tick();
    check("stray_ack_ren", 32'(read_en), 0);
    check("stray_ack_busy", 32'(busy), 0);

`ifdef SDRAM_PINGPONG_EN
    for (int k = 0; k < 4; k++) do_burst(1, a, b);
    tick();
    rd_vsync = 1'b1;
    tick();
    do_burst(0, a, b);
    check("pp_read_bank_first", 32'(b), 32'(BANK));
    do_burst(1, a, b);
    check("pp_write_bank_second", 32'(b), 32'(BANK ^ 2'b01));
    for (int k = 0; k < 3; k++) do_burst(1, a, b);
    tick();
    rd_vsync = 1'b1;
    tick();
    do_burst(0, a, b);
    check("pp_read_bank_second", 32'(b), 32'(BANK ^ 2'b01));
`endif

    // Random traffic, vsyncs, stray acks, variable ack latency and occasional resets.
    ack_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 5) == 0) wr_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rd_req = 1'($urandom_range(0, 1));
      wr_vsync = ($urandom_range(0, 39) == 0);
      rd_vsync = ($urandom_range(0, 39) == 0);
      if (write_en === 1'b0 && $urandom_range(0, 19) == 0) write_ack = 1'b1;
      if (read_en === 1'b0 && $urandom_range(0, 19) == 0) read_ack = 1'b1;
      RST_N = ($urandom_range(0, 1499) != 0);
    end
    RST_N  = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
